// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants, FSM state type and counter helper for the branch predictor
package branch_predictor_pkg;

    localparam logic [1:0] CAT_NONE     = 2'd0;
    localparam logic [1:0] CAT_COND     = 2'd1;
    localparam logic [1:0] CAT_DIRECT   = 2'd2;
    localparam logic [1:0] CAT_INDIRECT = 2'd3;

    localparam logic [1:0] CTR_WEAK_TAKEN = 2'd2;
    localparam logic [1:0] CTR_MAX        = 2'd3;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } bp_state_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'd0) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_table.sv
// rtl/bp_table.sv - branch predictor entry storage: registered lookup read, combinational
// read-modify-write port for training, single write port
module bp_table #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 24
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [29:0]      rd_target,
    output logic [1:0]       rd_ctr,
    output logic [1:0]       rd_cat,

    input  logic [IDX_W-1:0] mod_idx,
    output logic             mod_valid,
    output logic [TAG_W-1:0] mod_tag,
    output logic [29:0]      mod_target,
    output logic [1:0]       mod_ctr,

    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [29:0]      wr_target,
    input  logic [1:0]       wr_ctr,
    input  logic [1:0]       wr_cat
);

    logic             valid_mem  [0:ENTRIES-1];
    logic [TAG_W-1:0] tag_mem    [0:ENTRIES-1];
    logic [29:0]      target_mem [0:ENTRIES-1];
    logic [1:0]       ctr_mem    [0:ENTRIES-1];
    logic [1:0]       cat_mem    [0:ENTRIES-1];

    // Contents are not reset here; the owner's clear sequencer invalidates every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_mem[wr_idx]  <= wr_valid;
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
            ctr_mem[wr_idx]    <= wr_ctr;
            cat_mem[wr_idx]    <= wr_cat;
        end
    end

    // Read register holds its value when rd_en is low, so the prediction holds too.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_tag    <= '0;
            rd_target <= '0;
            rd_ctr    <= '0;
            rd_cat    <= '0;
        end else if (rd_en) begin
            rd_valid  <= valid_mem[rd_idx];
            rd_tag    <= tag_mem[rd_idx];
            rd_target <= target_mem[rd_idx];
            rd_ctr    <= ctr_mem[rd_idx];
            rd_cat    <= cat_mem[rd_idx];
        end
    end

    assign mod_valid  = valid_mem[mod_idx];
    assign mod_tag    = tag_mem[mod_idx];
    assign mod_target = target_mem[mod_idx];
    assign mod_ctr    = ctr_mem[mod_idx];

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB with 2-bit direction counters: clear sequencer, lookup hit logic
// and branch-unit training
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        bp_ready,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [1:0]  pred_category,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic [1:0]  upd_category
);

    localparam int TAG_W = 30 - IDX_W;

    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(ENTRIES - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    assign ready    = (state_q == ST_READY);
    assign bp_ready = ready;

    logic             accept;
    logic             pv_q, seen_q;
    logic [31:0]      pc_q;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [29:0]      rd_target;
    logic [1:0]       rd_ctr, rd_cat;

    assign accept = fetch_valid & ~flush & ready;

    // seen_q keeps pred_target at zero until the first accepted lookup after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q   <= 1'b0;
            seen_q <= 1'b0;
            pc_q   <= '0;
        end else begin
            pv_q <= accept;
            if (accept) begin
                seen_q <= 1'b1;
                pc_q   <= fetch_pc;
            end
        end
    end

    logic lk_hit, lk_taken;

    assign lk_hit   = rd_valid && (rd_tag == pc_q[31:IDX_W+2]);
    assign lk_taken = lk_hit && ((rd_cat == CAT_COND) ? rd_ctr[1] : 1'b1);

    assign pred_valid    = pv_q;
    assign pred_taken    = lk_taken;
    assign pred_target   = lk_taken ? {rd_target, 2'b00} : (seen_q ? pc_q + 32'd4 : 32'd0);
    assign pred_category = lk_hit ? rd_cat : CAT_NONE;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             mod_valid, upd_hit, upd_apply;
    logic [TAG_W-1:0] mod_tag;
    logic [29:0]      mod_target;
    logic [1:0]       mod_ctr;
    logic             unused_low_bits;

    assign upd_idx         = upd_pc[IDX_W+1:2];
    assign upd_tag         = upd_pc[31:IDX_W+2];
    assign upd_hit         = mod_valid && (mod_tag == upd_tag);
    assign upd_apply       = upd_valid && (upd_category != CAT_NONE) && ready;
    assign unused_low_bits = ^{upd_pc[1:0], upd_target[1:0]};

    logic             wr_en, wr_valid;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic [29:0]      wr_target;
    logic [1:0]       wr_ctr, wr_cat;

    // The write port is owned by the clear sequencer until READY, then by training.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = upd_idx;
        wr_valid  = 1'b1;
        wr_tag    = upd_tag;
        wr_target = upd_target[31:2];
        wr_ctr    = CTR_WEAK_TAKEN;
        wr_cat    = upd_category;
        if (!ready) begin
            wr_en    = 1'b1;
            wr_idx   = clr_idx_q;
            wr_valid = 1'b0;
        end else if (upd_apply) begin
            if (upd_hit) begin
                wr_en     = 1'b1;
                wr_ctr    = ctr_next(mod_ctr, upd_taken);
                wr_target = upd_taken ? upd_target[31:2] : mod_target;
            end else if (upd_taken) begin
                wr_en = 1'b1;
            end
        end
    end

    bp_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (accept),
        .rd_idx     (fetch_pc[IDX_W+1:2]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_ctr     (rd_ctr),
        .rd_cat     (rd_cat),
        .mod_idx    (upd_idx),
        .mod_valid  (mod_valid),
        .mod_tag    (mod_tag),
        .mod_target (mod_target),
        .mod_ctr    (mod_ctr),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_valid   (wr_valid),
        .wr_tag     (wr_tag),
        .wr_target  (wr_target),
        .wr_ctr     (wr_ctr),
        .wr_cat     (wr_cat)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        bp_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pred_category;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [1:0]  upd_category;

    int checks = 0;
    int passed = 0;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .flush         (flush),
        .bp_ready      (bp_ready),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .pred_category (pred_category),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_category  (upd_category)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic chk_pred(input string tag, input logic v, input logic t,
                            input logic [31:0] tgt, input logic [1:0] cat);
        chk({tag, ".valid"}, {31'd0, pred_valid}, {31'd0, v});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({tag, ".target"}, pred_target, tgt);
        chk({tag, ".cat"}, {30'd0, pred_category}, {30'd0, cat});
    endtask

    task automatic lookup(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken,
                          input logic [31:0] target, input logic [1:0] cat);
        upd_valid    = 1'b1;
        upd_pc       = pc;
        upd_taken    = taken;
        upd_target   = target;
        upd_category = cat;
        step();
        upd_valid    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_category = '0;
        step();
        step();
        chk("rst.bp_ready", {31'd0, bp_ready}, 32'd0);
        chk_pred("rst", 1'b0, 1'b0, 32'h0, 2'd0);

        rst = 1'b0;
        fetch_valid = 1'b1;
        fetch_pc = 32'h1c00_0030;
        for (int i = 1; i <= 64; i++) begin
            if (i == 64) begin
                upd_valid = 1'b1; upd_pc = 32'h1c00_0030; upd_taken = 1'b1;
                upd_target = 32'h1c00_0300; upd_category = 2'd1;
            end
            step();
            if (i == 63) chk("clear.bp_ready_c63", {31'd0, bp_ready}, 32'd0);
            if (i < 64)  chk("clear.pred_valid", {31'd0, pred_valid}, 32'd0);
        end
        chk("clear.bp_ready_c64", {31'd0, bp_ready}, 32'd1);
        chk("clear.pred_valid_c64", {31'd0, pred_valid}, 32'd0);
        fetch_valid = 1'b0;
        upd_valid = 1'b0;

        lookup(32'h1c00_0030);
        chk_pred("clear_upd_dropped", 1'b1, 1'b0, 32'h1c00_0034, 2'd0);
        lookup(32'h1c00_0000);
        chk_pred("empty", 1'b1, 1'b0, 32'h1c00_0004, 2'd0);

        update(32'h1c00_0010, 1'b1, 32'h1c00_0100, 2'd1);
        lookup(32'h1c00_0010);
        chk_pred("alloc", 1'b1, 1'b1, 32'h1c00_0100, 2'd1);

        update(32'h1c00_0010, 1'b0, 32'h1c00_0014, 2'd1);
        update(32'h1c00_0010, 1'b0, 32'h1c00_0014, 2'd1);
        lookup(32'h1c00_0010);
        chk_pred("ctr0", 1'b1, 1'b0, 32'h1c00_0014, 2'd1);

        for (int i = 0; i < 4; i++) update(32'h1c00_0010, 1'b1, 32'h1c00_0100, 2'd1);
        lookup(32'h1c00_0010);
        chk_pred("ctr3", 1'b1, 1'b1, 32'h1c00_0100, 2'd1);
        update(32'h1c00_0010, 1'b0, 32'h1c00_0014, 2'd1);
        lookup(32'h1c00_0010);
        chk_pred("sat_then_dec", 1'b1, 1'b1, 32'h1c00_0100, 2'd1);
        update(32'h1c00_0010, 1'b0, 32'h1c00_0014, 2'd1);
        lookup(32'h1c00_0010);
        chk_pred("ctr1", 1'b1, 1'b0, 32'h1c00_0014, 2'd1);

        update(32'h1c00_0110, 1'b1, 32'h1c00_0200, 2'd1);
        lookup(32'h1c00_0010);
        chk_pred("alias_evicted", 1'b1, 1'b0, 32'h1c00_0014, 2'd0);
        lookup(32'h1c00_0110);
        chk_pred("alias_new", 1'b1, 1'b1, 32'h1c00_0200, 2'd1);
        update(32'h1c00_0110, 1'b0, 32'h1c00_0114, 2'd1);
        lookup(32'h1c00_0110);
        chk_pred("alias_ctr_was_2", 1'b1, 1'b0, 32'h1c00_0114, 2'd1);

        fetch_valid = 1'b1; fetch_pc = 32'h1c00_0020;
        update(32'h1c00_0020, 1'b1, 32'h1c00_0400, 2'd2);
        fetch_valid = 1'b0;
        chk_pred("same_edge_old", 1'b1, 1'b0, 32'h1c00_0024, 2'd0);
        lookup(32'h1c00_0020);
        chk_pred("same_edge_next", 1'b1, 1'b1, 32'h1c00_0400, 2'd2);

        update(32'h1c00_0040, 1'b1, 32'h1c00_0500, 2'd3);
        update(32'h1c00_0040, 1'b0, 32'h1c00_0044, 2'd3);
        update(32'h1c00_0040, 1'b0, 32'h1c00_0044, 2'd3);
        lookup(32'h1c00_0040);
        chk_pred("indirect_ctr0", 1'b1, 1'b1, 32'h1c00_0500, 2'd3);

        update(32'h1c00_0050, 1'b1, 32'h1c00_0600, 2'd0);
        lookup(32'h1c00_0050);
        chk_pred("cat0_ignored", 1'b1, 1'b0, 32'h1c00_0054, 2'd0);
        update(32'h1c00_0060, 1'b0, 32'h1c00_0700, 2'd1);
        lookup(32'h1c00_0060);
        chk_pred("nt_miss_no_alloc", 1'b1, 1'b0, 32'h1c00_0064, 2'd0);

        step();
        chk_pred("idle_hold", 1'b0, 1'b0, 32'h1c00_0064, 2'd0);
        flush = 1'b1;
        lookup(32'h1c00_0020);
        flush = 1'b0;
        chk_pred("flush", 1'b0, 1'b0, 32'h1c00_0064, 2'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("midclear.bp_ready", {31'd0, bp_ready}, 32'd0);
        rst = 1'b1;
        step();
        chk_pred("rst2", 1'b0, 1'b0, 32'h0, 2'd0);
        rst = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 63) chk("reclear.bp_ready_c63", {31'd0, bp_ready}, 32'd0);
        end
        chk("reclear.bp_ready_c64", {31'd0, bp_ready}, 32'd1);
        lookup(32'h1c00_0020);
        chk_pred("reclear_empty", 1'b1, 1'b0, 32'h1c00_0024, 2'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer with 2-bit saturating direction counters. It sits beside the fetch stage and is trained by the execute-stage branch unit. Fetch presents a PC and receives a registered prediction (taken, target, category) one cycle later. The branch unit's resolved outcome writes the table through a single synchronous update port. After reset, an internal clear sequencer invalidates every entry before the predictor reports ready.

## Interface
Parameters:
- `ENTRIES`, 64: number of table entries; power of two, at least 4.
- `IDX_W`, $clog2(ENTRIES): index width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `fetch_valid` in 1: lookup request this cycle.
- `fetch_pc` in 32: lookup PC; bits [1:0] are ignored.
- `flush` in 1: pipeline redirect; kills the lookup in flight.
- `bp_ready` out 1: table clear complete.
- `pred_valid` out 1: prediction valid, registered.
- `pred_taken` out 1: predicted taken.
- `pred_target` out 32: predicted next PC.
- `pred_category` out 2: stored category of the hit entry; 0 on miss.
- `upd_valid` in 1: resolved branch, driven by the branch unit's `branch_valid`.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: resolved direction (`branch_status`).
- `upd_target` in 32: resolved target (`branch_addr_calculated`).
- `upd_category` in 2: branch class. 0 = not a branch, 1 = conditional, 2 = direct unconditional, 3 = indirect (JIRL).

## Operation
- Entry fields: `valid`, `tag` = pc[31:IDX_W+2], `target`[31:2], `ctr`[1:0], `cat`[1:0].
- Index = pc[IDX_W+1:2].
- A lookup hits when `valid` is set and `tag` matches.

Lookup result on a hit:
- `pred_taken` = (`cat`==1) ? `ctr`[1] : 1.
- `pred_target` = `pred_taken` ? {`target`,2'b00} : `fetch_pc`+4.
- `pred_category` = `cat`.

Lookup result on a miss:
- `pred_taken`=0, `pred_target`=`fetch_pc`+4, `pred_category`=0.

Update, applied only when `upd_valid` is set, `upd_category`≠0 and the FSM is in READY:
- Hit: `ctr` saturating +1 if taken, −1 if not taken, bounded to 0..3. `cat` is overwritten. `target` is overwritten only if taken.
- Miss and taken: allocate by overwriting the indexed entry. `valid`=1, tag/target from the update, `ctr`=2, `cat`=`upd_category`.
- Miss and not taken: no change.

FSM states:
- CLEAR: the `clr_idx` counter writes `valid`=0 to one entry per cycle, starting at 0. After writing entry ENTRIES−1 the FSM moves to READY.
- READY: normal operation; terminal until the next `rst`.
- `rst` in any state forces CLEAR with `clr_idx`=0, including mid-clear.

While in CLEAR: `bp_ready`=0, lookups return `pred_valid`=0, updates are dropped.

## Timing
- Reset values: `bp_ready`=0, `pred_valid`=0, `pred_taken`=0, `pred_target`=0, `pred_category`=0, FSM=CLEAR, `clr_idx`=0.
- Clear duration: the cycle after `rst` deasserts is the first CLEAR cycle. `bp_ready` rises exactly ENTRIES cycles later.
- Lookup latency is 1: `fetch_pc` is sampled at edge N and the prediction is valid after edge N.
- `pred_valid` after edge N = `fetch_valid` & ~`flush` & READY, all sampled at edge N. The other prediction outputs hold their previous values when `pred_valid` is 0.
- Updates write the table at the edge where they are sampled.
- Lookup and update to the same index at the same edge: the lookup reads the pre-update contents (read-old, no bypass). The new contents are visible from the next lookup onward.
- Back-to-back updates to the same entry on consecutive cycles each see the previous write.
- No backpressure: a lookup can be accepted every cycle and an update can be accepted every cycle.

## Structure
- The shared package holds category constants (CAT_NONE=0, CAT_COND=1, CAT_DIRECT=2, CAT_INDIRECT=3), counter constants (CTR_WEAK_TAKEN=2, CTR_MAX=3), and the FSM state typedef.
- One sub-module, `bp_table`: the entry storage with one synchronous read port and one write port. The table must map to flops or distributed RAM.
- The clear FSM, hit logic and update logic live in `branch_predictor`.

## Test plan
- Reset with ENTRIES=64, then deassert `rst` → `bp_ready` stays low for 64 cycles and rises on the 65th. `fetch_valid`=1 during this window gives `pred_valid`=0. An update issued during CLEAR has no effect.
- Lookup `fetch_pc`=0x1c000000 on an empty table → next cycle `pred_valid`=1, `pred_taken`=0, `pred_target`=0x1c000004, `pred_category`=0.
- Taken cat-1 update at pc 0x1c000010 with target 0x1c000100 → lookup predicts taken with target 0x1c000100. Two not-taken updates follow → `ctr`=0, prediction not taken, target 0x1c000014. Four taken updates from `ctr`=0 → `ctr` saturates at 3.
- Alias: allocate pc 0x1c000010, then a taken update at pc 0x1c000110 (same index, different tag) with target 0x1c000200 → a lookup of 0x1c000010 misses. A lookup of 0x1c000110 hits with target 0x1c000200 and `ctr`=2.
- Same-edge lookup and first taken update of pc 0x1c000020 → that lookup misses. The next lookup hits taken. A cat-3 entry with `ctr`=0 still predicts taken.
- `flush`=1 with `fetch_valid`=1 → `pred_valid`=0 next cycle. `rst` asserted at clear cycle 30 → `bp_ready` rises 64 cycles after the second deassertion.
